// File: rtl/bank_fetch_pkg.sv
// bank_fetch_pkg -- shared definitions for the bank_fetch block.
//   state_t       : fetch controller states (IDLE, FETCH, DRAIN)
//   WORD_SIZE_DEF : default data word width
//   NUM_BANKS     : number of interleaved banks (word i lives in bank i mod 4)
//   BANK_IDX_W    : width of a bank index
package bank_fetch_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int NUM_BANKS     = 4;
  localparam int BANK_IDX_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2 -- two-entry FIFO between the bank read path and the output stream.
//   clk, rst_n : clock, asynchronous active-low reset (clears contents and pointers)
//   push, din  : write request and data (accepted when not full, or when full
//                and a pop happens in the same cycle)
//   pop        : read request (ignored while empty)
//   dout       : head entry, held stable until popped
//   empty      : no entries stored
//   count      : number of stored entries (0..2)
module skid_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         pop_ok;
  logic         push_ok;

  // When full, a simultaneous pop frees the slot the write pointer already
  // points at, so both operations can complete in the same cycle.
  assign pop_ok  = pop && (count_reg != 2'd0);
  assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == 2'd0);
  assign count = count_reg;

endmodule

// File: rtl/bank_fetch.sv
// bank_fetch -- streams LENGTH words out of four interleaved banks.
// Word i is read from bank i mod 4 at row base_addr + i/4 (row wraps).
// Reads are credit-limited so the two-entry output FIFO can never overflow.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, base_addr,
//   length             : one-cycle request (ignored while busy); length 0 legal
//   busy, done         : transfer active; one-cycle completion pulse
//   bank_rd_en,
//   bank_addr          : read strobe and shared row address to all banks
//   bank_sel           : bank index of the read issued last cycle (mux select)
//   bank_rdata         : muxed bank data, valid the cycle after bank_rd_en
//   out_data, out_valid,
//   out_ready          : output stream
//   stall_cycles       : present only with BANK_FETCH_STALL_CNT_EN defined;
//                        saturating count of busy cycles with out_valid && !out_ready
module bank_fetch
  import bank_fetch_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      length,
  output logic                  busy,
  output logic                  done,
  output logic                  bank_rd_en,
  output logic [ADDR_W-1:0]     bank_addr,
  output logic [BANK_IDX_W-1:0] bank_sel,
  input  logic [WORD_SIZE-1:0]  bank_rdata,
  output logic [WORD_SIZE-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef BANK_FETCH_STALL_CNT_EN
  ,
  output logic [LEN_W-1:0]      stall_cycles
`endif
);

  state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]       base_reg;
  logic [LEN_W-1:0]        len_reg;
  logic [LEN_W-1:0]        issued_reg;
  logic                    inflight_reg;
  logic [BANK_IDX_W-1:0]   bank_sel_reg;
  logic                    zero_done_reg;

  logic                    start_ok;
  logic                    pop;
  logic                    fifo_empty;
  logic [1:0]              fifo_count;
  logic [2:0]              occupancy;
  logic                    issue;
  logic                    last_issue;
  logic                    drain_done;

  assign start_ok = (state_reg == IDLE) && start;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Entries that will be held once this cycle's pop and the in-flight word
  // settle. Counting the pop lets a new read go out every cycle while the
  // consumer keeps up; without it the stream would stall on alternate cycles.
  assign occupancy = 3'(fifo_count) + 3'(inflight_reg) - 3'(pop);

  assign issue      = (state_reg == FETCH) && (issued_reg != len_reg) && (occupancy < 3'd2);
  assign last_issue = issue && (issued_reg == len_reg - LEN_W'(1));

  always_comb begin
    state_next = state_reg;
    drain_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (length != '0)) state_next = FETCH;
      end
      FETCH: begin
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !inflight_reg) begin
          state_next = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      len_reg       <= '0;
      issued_reg    <= '0;
      inflight_reg  <= 1'b0;
      bank_sel_reg  <= '0;
      zero_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      inflight_reg  <= issue;
      zero_done_reg <= start_ok && (length == '0);
      if (start_ok) begin
        base_reg   <= base_addr;
        len_reg    <= length;
        issued_reg <= '0;
      end else if (issue) begin
        issued_reg <= issued_reg + LEN_W'(1);
      end
      if (issue) bank_sel_reg <= issued_reg[BANK_IDX_W-1:0];
    end
  end

  assign bank_rd_en = issue;
  assign bank_addr  = base_reg + ADDR_W'(issued_reg >> BANK_IDX_W);
  assign bank_sel   = bank_sel_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = zero_done_reg | drain_done;

  skid_fifo2 #(
    .W(WORD_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_reg),
    .din   (bank_rdata),
    .pop   (pop),
    .dout  (out_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef BANK_FETCH_STALL_CNT_EN
  logic [LEN_W-1:0] stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_reg <= '0;
    end else if (start_ok) begin
      stall_reg <= '0;
    end else if (busy && out_valid && !out_ready && (stall_reg != '1)) begin
      stall_reg <= stall_reg + LEN_W'(1);
    end
  end

  assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_bank_fetch.sv
// tb_bank_fetch -- randomized scoreboard bench for bank_fetch.
// The bench models the four banks: a word's value is a hash of (bank, row),
// so a wrong row, wrong bank select, lost or duplicated word shows up as a
// data mismatch. Expected words are pushed per transfer; a forked monitor
// pops and compares whenever the DUT hands over a word.
module tb_bank_fetch;
  localparam int WS = 16;
  localparam int AW = 10;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, bank_rd_en, out_valid;
  logic [AW-1:0] bank_addr;
  logic [1:0]    bank_sel;
  logic [WS-1:0] bank_rdata, out_data;
  logic          out_ready = 1'b0;
`ifdef BANK_FETCH_STALL_CNT_EN
  logic [LW-1:0] stall_cycles;
`endif

  bank_fetch #(.WORD_SIZE(WS), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .bank_rd_en (bank_rd_en),
    .bank_addr  (bank_addr),
    .bank_sel   (bank_sel),
    .bank_rdata (bank_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef BANK_FETCH_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WS-1:0] word_of(input logic [1:0] b, input logic [AW-1:0] r);
    logic [31:0] t;
    t = {20'd0, b, r} * 32'd2654435761;
    return t[31:16];
  endfunction

  // Bank model: row captured on the read strobe, data presented next cycle
  // through the DUT-driven select.
  logic [AW-1:0] addr_q = '0;
  always @(posedge clk) if (bank_rd_en) addr_q <= bank_addr;
  assign bank_rdata = word_of(bank_sel, addr_q);

  int rd_cnt = 0;
  int acc_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= 0;
      acc_cnt <= 0;
    end else begin
      rd_cnt  <= rd_cnt + int'(bank_rd_en);
      acc_cnt <= acc_cnt + int'(out_valid && out_ready);
    end
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int max_out = 0;
  int n_xfer = 0;
  logic [WS-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rd_en"}, 32'(bank_rd_en), 0);
    chk({tag, "_bank_addr"}, 32'(bank_addr), 0);
    chk({tag, "_bank_sel"}, 32'(bank_sel), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
  endtask

  // mode 0: out_ready held high; 1: random out_ready; 2: low 10 cycles then high
  task automatic run_xfer(input logic [AW-1:0] b, input logic [LW-1:0] l, input int mode, input bit inj);
    int k;
    int rd0;
    int d0;
    bit got;
    k = 0;
    while (busy && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    chk("idle_before_start", 32'(busy), 0);
    @(posedge clk); #1;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(word_of(2'(i % 4), b + AW'(i / 4)));
    rd0 = rd_cnt;
    d0 = done_cnt;
    base_addr = b;
    length = l;
    start = 1'b1;
    out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    length = LW'($urandom);
    k = 0;
    got = done;
    if (l == 0) begin
      chk("zero_done_next_cycle", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
    end
    while (!got && k < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : (k >= 10);
      @(posedge clk); #1;
      k++;
      if (inj) begin
        start = (k == 2);
        base_addr = AW'($urandom);
        length = LW'($urandom_range(1, 30));
      end
      if (mode == 0 && l != 0 && k == 1) chk("first_valid_early", 32'(out_valid), 0);
      if (mode == 0 && l != 0 && k == 2) chk("first_valid", 32'(out_valid), 1);
      got = done;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 1);
    if (mode == 0) chk("done_latency", 32'(k), (l == 0) ? 32'd0 : 32'(l) + 32'd2);
    @(posedge clk); #1;
    chk("done_single_pulse", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
    chk("read_count", 32'(rd_cnt - rd0), 32'(l));
    chk("done_count", 32'(done_cnt - d0), 1);
    chk("all_words_out", 32'(exp_q.size()), 0);
    chk("outstanding_le_2", 32'(max_out <= 2), 1);
    n_xfer++;
    $display("xfer %0d: base=%0d len=%0d mode=%0d inj=%0d cycles=%0d checks=%0d errors=%0d",
             n_xfer, b, l, mode, inj, k, checks, errors);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (done) done_cnt++;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_word: got %0h, required no word", out_data);
            end else begin
              chk("word", 32'(out_data), 32'(exp_q.pop_front()));
            end
          end
          if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    run_xfer(10'd5, 12'd8, 0, 1'b0);
    run_xfer(10'd7, 12'd0, 0, 1'b0);
    run_xfer(10'd100, 12'd6, 2, 1'b0);
    run_xfer(10'd1023, 12'd8, 0, 1'b0);
    run_xfer(10'd33, 12'd9, 0, 1'b1);
    run_xfer(10'd200, 12'd12, 1, 1'b1);

    // Reset in the middle of a transfer, then a clean transfer afterwards.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) exp_q.push_back(word_of(2'(i % 4), 10'd40 + AW'(i / 4)));
    base_addr = 10'd40;
    length = 12'd8;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_mid_reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("mid-transfer reset applied: checks=%0d errors=%0d", checks, errors);
    run_xfer(10'd12, 12'd5, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      logic [LW-1:0] l;
      int m;
      l = LW'($urandom_range(0, 20));
      m = int'($urandom_range(0, 2));
      run_xfer(AW'($urandom), l, m, (l >= 4) && ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
